// File: rtl/addmul_pkg.sv
// +------------------------------------------------------------------+
// | addmul_pkg : shared constants and S1 stage type for addmul_arbiter |
// | Revision   : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package addmul_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  // S1 fields are sized for the largest supported configuration (8 requesters,
  // 16-bit operands); narrower instances zero-extend into them.
  localparam int MAX_DATA_W = 16;
  localparam int MAX_ID_W   = 3;

  typedef struct packed {
    logic                  valid;
    logic [MAX_DATA_W-1:0] sum;
    logic [MAX_DATA_W-1:0] c;
    logic [MAX_ID_W-1:0]   id;
  } s1_stage_t;

endpackage

`default_nettype wire

// File: rtl/addmul_arbiter_if.sv
// +------------------------------------------------------------------+
// | addmul_arbiter_if : requester and result handshake bundle          |
// | Revision          : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

interface addmul_arbiter_if
  import addmul_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DATA_W-1:0]  req_a;
  logic [NUM_REQ*DATA_W-1:0]  req_b;
  logic [NUM_REQ*DATA_W-1:0]  req_c;
  logic                       out_valid;
  logic                       out_ready;
  logic [2*DATA_W-1:0]        out_result;
  logic [$clog2(NUM_REQ)-1:0] out_id;

  modport master (
    output req_valid, req_a, req_b, req_c, out_ready,
    input  req_ready, out_valid, out_result, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, out_ready,
    output req_ready, out_valid, out_result, out_id
  );

endinterface

`default_nettype wire

// File: rtl/addmul_rr_arb.sv
// +------------------------------------------------------------------+
// | addmul_rr_arb : combinational round-robin grant, registered pointer |
// | Revision      : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

module addmul_rr_arb
  import addmul_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic [NUM_REQ-1:0]         req_valid,
  input  wire logic                       enable,
  output logic      [NUM_REQ-1:0]         grant,
  output logic      [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                            grant_any
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0] ptr;

  // Scan from ptr upward with wrap; the first valid candidate wins.
  always_comb begin
    logic [ID_W:0] idx;
    idx       = '0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (enable && !grant_any && req_valid[idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/addmul_arbiter.sv
// +------------------------------------------------------------------+
// | addmul_arbiter : round-robin N-to-1 arbiter feeding (a+b)*c pipe   |
// | Revision       : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module addmul_arbiter
  import addmul_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  addmul_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                advance;
  logic                arb_en;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [DATA_W-1:0]   sel_c;
  logic [DATA_W-1:0]   sum;
  s1_stage_t           s1_q;
  logic [DATA_W-1:0]   s1_sum;
  logic [DATA_W-1:0]   s1_c;
  logic                out_valid_q;
  logic [2*DATA_W-1:0] result_q;
  logic [ID_W-1:0]     id_q;
  logic                unused_s1_hi;

  // Whole pipe moves together; rst_n gates grants so nothing is accepted in reset.
  assign advance = !out_valid_q || bus.out_ready;
  assign arb_en  = advance && rst_n;

  addmul_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  assign sel_a = bus.req_a[grant_id*DATA_W +: DATA_W];
  assign sel_b = bus.req_b[grant_id*DATA_W +: DATA_W];
  assign sel_c = bus.req_c[grant_id*DATA_W +: DATA_W];
  assign sum   = sel_a + sel_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (advance) begin
      s1_q.valid <= grant_any;
      s1_q.sum   <= MAX_DATA_W'(sum);
      s1_q.c     <= MAX_DATA_W'(sel_c);
      s1_q.id    <= MAX_ID_W'(grant_id);
    end
  end

  assign s1_sum       = s1_q.sum[DATA_W-1:0];
  assign s1_c         = s1_q.c[DATA_W-1:0];
  assign unused_s1_hi = ^{s1_q.sum >> DATA_W, s1_q.c >> DATA_W, s1_q.id >> ID_W};

  // Result and id only load on a real S1 entry so a bubble leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      id_q        <= '0;
    end else if (advance) begin
      out_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        result_q <= (2*DATA_W)'(s1_sum) * (2*DATA_W)'(s1_c);
        id_q     <= s1_q.id[ID_W-1:0];
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_id     = id_q;

endmodule

`default_nettype wire

// File: tb/tb_addmul_arbiter.sv
// +------------------------------------------------------------------+
// | tb_addmul_arbiter : directed self-checking bench for addmul_arbiter |
// | Revision          : 1.0                                             |
// +------------------------------------------------------------------+
`default_nettype none

module tb_addmul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   fails;

  addmul_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  addmul_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_c[i*DATA_W +: DATA_W] = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests_run++; if (bus.out_result !== 16'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", bus.out_result); end
    tests_run++; if (bus.out_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", bus.out_id); end
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_ops(2, 8'd3, 8'd4, 8'd5);
    bus.req_valid = 4'b0100;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_latency1: out_valid got %b expected 0", bus.out_valid); end
    @(negedge clk);
    #1;
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    tests_run++; if (bus.out_result !== 16'd35) begin fails++; $display("FAIL single_result: got %0d expected 35", bus.out_result); end
    tests_run++; if (bus.out_id !== 2'd2) begin fails++; $display("FAIL single_id: got %0d expected 2", bus.out_id); end
    @(negedge clk);
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_bubble: out_valid got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    set_ops(1, 8'd200, 8'd100, 8'd3);
    bus.req_valid = 4'b0010;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL ovf_ready: got %b expected 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b expected 1", bus.out_valid); end
    tests_run++; if (bus.out_result !== 16'd132) begin fails++; $display("FAIL ovf_result: got %0d expected 132", bus.out_result); end
    tests_run++; if (bus.out_id !== 2'd1) begin fails++; $display("FAIL ovf_id: got %0d expected 1", bus.out_id); end
  endtask

  task automatic test_max_product();
    @(negedge clk);
    set_ops(0, 8'd255, 8'd0, 8'd255);
    bus.req_valid = 4'b0001;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL max_ready: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL max_valid: got %b expected 1", bus.out_valid); end
    tests_run++; if (bus.out_result !== 16'hFE01) begin fails++; $display("FAIL max_result: got %h expected fe01", bus.out_result); end
    tests_run++; if (bus.out_id !== 2'd0) begin fails++; $display("FAIL max_id: got %0d expected 0", bus.out_id); end
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_rdy;
    logic [15:0] exp_res;
    logic [1:0]  exp_id;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_ops(i, 8'(i + 1), 8'd10, 8'd2);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        exp_rdy = 4'b0001 << (k % 4);
        tests_run++; if (bus.req_ready !== exp_rdy) begin fails++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy); end
      end
      if (k >= 2 && k <= 9) begin
        exp_id  = 2'((k - 2) % 4);
        exp_res = 16'((int'(exp_id) + 11) * 2);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_result !== exp_res) begin
          fails++;
          $display("FAIL fair_out[%0d]: got v=%b id=%0d res=%0d expected v=1 id=%0d res=%0d",
                   k, bus.out_valid, bus.out_id, bus.out_result, exp_id, exp_res);
        end
      end else if (k >= 10) begin
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL fair_drain[%0d]: out_valid got %b expected 0", k, bus.out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_res [4] = '{16'd9, 16'd52, 16'd115, 16'd198};
    logic [3:0]  pending;
    int          next_g;
    int          delivered;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_ops(i, 8'(10 * i + 1), 8'd2, 8'(i + 3));
    end
    pending   = 4'hF;
    next_g    = 0;
    delivered = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.req_valid = pending;
      bus.out_ready = !(k >= 3 && k <= 7);
      #1;
      if (bus.req_ready !== 4'b0000) begin
        tests_run++;
        if (next_g > 3 || bus.req_ready !== (4'b0001 << next_g)) begin
          fails++;
          $display("FAIL bp_grant[%0d]: got %b expected grant index %0d", k, bus.req_ready, next_g);
        end
        next_g++;
      end
      if (k >= 3 && k <= 7) begin
        tests_run++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'd52 || bus.out_id !== 2'd1) begin
          fails++;
          $display("FAIL bp_hold[%0d]: got v=%b id=%0d res=%0d expected v=1 id=1 res=52",
                   k, bus.out_valid, bus.out_id, bus.out_result);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        tests_run++;
        if (delivered > 3 || bus.out_result !== exp_res[delivered & 3] || bus.out_id !== 2'(delivered)) begin
          fails++;
          $display("FAIL bp_deliver[%0d]: got id=%0d res=%0d expected id=%0d res=%0d",
                   delivered, bus.out_id, bus.out_result, delivered, exp_res[delivered & 3]);
        end
        delivered++;
      end
      pending = pending & ~bus.req_ready;
    end
    tests_run++; if (delivered != 4) begin fails++; $display("FAIL bp_count: got %0d results expected 4", delivered); end
    tests_run++; if (next_g != 4) begin fails++; $display("FAIL bp_grants: got %0d grants expected 4", next_g); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_ops(0, 8'd1, 8'd1, 8'd1);
    set_ops(1, 8'd2, 8'd2, 8'd2);
    @(negedge clk);
    bus.req_valid = 4'b0011;
    bus.out_ready = 1'b0;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_grant0: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL rmid_grant1: got %b expected 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rmid_inflight: out_valid got %b expected 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_valid: got %b expected 0", bus.out_valid); end
    tests_run++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL rmid_ready_in_reset: got %b expected 0000", bus.req_ready); end
    tests_run++; if (bus.out_result !== 16'd0 || bus.out_id !== 2'd0) begin fails++; $display("FAIL rmid_clear: got id=%0d res=%0d expected id=0 res=0", bus.out_id, bus.out_result); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_ptr_reset: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_stale: out_valid got %b expected 0", bus.out_valid); end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_result !== 16'd2) begin
      fails++;
      $display("FAIL rmid_first_after: got v=%b id=%0d res=%0d expected v=1 id=0 res=2",
               bus.out_valid, bus.out_id, bus.out_result);
    end
    @(negedge clk);
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_tail: out_valid got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_single();
    test_overflow();
    test_max_product();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addmul_arbiter.md
ADDMUL_ARBITER -- requirements
Module: addmul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, the operand width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_a, req_b, req_c  input  NUM_REQ*DATA_W each  packed operands, requester i at slice [i*DATA_W +: DATA_W].
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_result  output  2*DATA_W  (a+b)*c.
REQ-011 SHALL have port out_id  output  $clog2(NUM_REQ)  index of originating requester.

Function
REQ-012 SHALL compute sum = (a+b) truncated to DATA_W bits (carry discarded), then result = sum*c at full 2*DATA_W width.
REQ-013 SHALL use a two-stage pipeline: S1 registers sum, c, id; S2 registers result, id, out_valid.
REQ-014 SHALL define advance = !out_valid || out_ready; when advance=0 both stages hold and no grant issues.
REQ-015 SHALL transfer on requester i exactly when req_valid[i] && req_ready[i] in the same cycle.
REQ-016 SHALL assert at most one req_ready bit, only when advance=1, combinationally from req_valid, the RR pointer and advance.
REQ-017 SHALL grant round-robin: search starts at pointer ptr, wraps from NUM_REQ-1 to 0; first valid index wins.
REQ-018 SHALL, on a grant to index g, set ptr to g+1 modulo NUM_REQ; ptr SHALL NOT change without a grant.
REQ-019 SHALL produce out_valid exactly 2 cycles after acceptance when advance stays 1 (latency 2, throughput 1/cycle).
REQ-020 SHALL hold out_result and out_id stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when an S1 bubble reaches S2 with out_ready=1, deassert out_valid the following cycle.
REQ-022 SHALL ignore req_a/b/c of non-granted requesters; a requester dropping req_valid before grant loses nothing.
REQ-023 SHALL preserve result order equal to grant order; no result dropped or duplicated under any backpressure pattern.

Reset
REQ-024 SHALL, on rst_n low, immediately clear out_valid, S1 valid, out_result, out_id and set ptr=0.
REQ-025 SHALL drive req_ready all-zero while rst_n is low; in-flight operations are discarded, not completed.
REQ-026 SHALL accept requests from the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL place the default NUM_REQ and DATA_W constants and the S1 stage struct typedef (valid, sum, c, id) in shared package addmul_pkg.
REQ-028 SHALL instantiate one sub-module addmul_rr_arb (combinational grant plus registered ptr); the datapath SHALL remain inline.

Verification
REQ-029 Single request: req 2 a=3 b=4 c=5, out_ready=1 -> out_valid two cycles later, out_result=35, out_id=2.
REQ-030 Overflow: a=200 b=100 c=3 -> sum wraps to 44, out_result=132 (not 900).
REQ-031 Fairness: all 4 valid continuously, out_ready=1 -> grants 0,1,2,3,0,... ; out_id sequence matches.
REQ-032 Backpressure: 4 requests back-to-back, out_ready low 5 cycles mid-stream -> req_ready all-zero during stall, results held stable, all 4 delivered in order with no loss.
REQ-033 Reset mid-operation: rst_n low with two results in flight -> out_valid=0 immediately, ptr=0, none of the in-flight results appear after release.
REQ-034 Max product: a=255 b=0 c=255 -> out_result=65025 (16'hFE01).
